axi_rd_arbiter: RTL and testbench

//  Shares the single AXI read channel pair (AR/R) between the instruction-side and data-side

---
 rtl/axi_rd_arbiter_pkg.sv | 22 ++
 rtl/axi_rd_arbiter_if.sv | 40 ++++
 rtl/axi_rd_arbiter_rr_arb2.sv | 42 ++++
 rtl/axi_rd_arbiter.sv | 169 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter: burst encoding,
// FSM state encoding and requester port indices.
package axi_rd_arbiter_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Requester port indices
    localparam int PORT_ICACHE = 0;
    localparam int PORT_DCACHE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } arb_state_e;

    // Index of the port that is not p
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read address / read data channel bundle (AR + R).
// master: the side issuing reads (the arbiter); slave: the memory/interconnect side.
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant. With both ports requesting, the port at the
// priority pointer wins; on advance the pointer moves to the loser so that
// back-to-back contention alternates strictly.
module rr_arb2 #(
    parameter int RESET_PRIO = 1
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    import axi_rd_arbiter_pkg::*;

    logic ptr_q;
    logic ptr_d;

    // Grant decode and pointer update
    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        if (advance && (grant != 2'b00)) begin
            ptr_d = other_port(grant[1]);
        end
    end

    // Priority pointer register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q <= (RESET_PRIO != 0);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel pair between the I-cache (port 0) and the
// D-cache (port 1). A single read is in flight at a time and the winning
// port owns the channel until the rlast beat of its burst.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int RESET_PRIO = 1
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_len,
    input  logic [2:0]        p0_size,
    output logic              p0_addr_ok,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,
    output logic              p0_rlast,

    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_len,
    input  logic [2:0]        p1_size,
    output logic              p1_addr_ok,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic              p1_rlast,

    axi_rd_arbiter_if.master  axi
);

    arb_state_e        state_q,   state_d;
    logic              owner_q,   owner_d;
    logic [ADDR_W-1:0] araddr_q,  araddr_d;
    logic [7:0]        arlen_q,   arlen_d;
    logic [2:0]        arsize_q,  arsize_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q,  rready_d;

    logic [1:0]        req_vec;
    logic [1:0]        grant;
    logic              in_idle;
    logic              in_r;
    logic              advance;

    logic [1:0]        addr_ok_vec;
    logic [1:0]        rvalid_vec;
    logic [1:0]        rlast_vec;
    logic [DATA_W-1:0] rdata_arr [2];

    // rid is never checked (only one read outstanding) and rresp is ignored
    logic              unused_r_fields;
    assign unused_r_fields = ^{axi.rid, axi.rresp};

    assign req_vec = {p1_req, p0_req};
    assign in_idle = (state_q == ST_IDLE);
    assign in_r    = (state_q == ST_R);
    assign advance = in_idle && (req_vec != 2'b00);

    rr_arb2 #(
        .RESET_PRIO (RESET_PRIO)
    ) u_rr_arb2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     (req_vec),
        .advance (advance),
        .grant   (grant)
    );

    // Acceptance is only ever signalled from IDLE; later requests wait there
    assign addr_ok_vec = grant & {2{in_idle}};

    // FSM next state: latch the winner's request, issue AR, drain R until rlast
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d   = grant[1];
                    araddr_d  = grant[1] ? p1_addr : p0_addr;
                    arlen_d   = grant[1] ? p1_len  : p0_len;
                    arsize_d  = grant[1] ? p1_size : p0_size;
                    arvalid_d = 1'b1;
                    state_d   = ST_AR;
                end
            end
            ST_AR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (axi.rvalid && axi.rlast) begin
                    rready_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and AR field registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign axi.arid    = {{(ID_W-1){1'b0}}, owner_q};
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    // Route the R channel to the owning port only while a burst is being drained
    for (genvar gi = 0; gi < 2; gi++) begin : g_port_rsp
        logic sel;
        assign sel            = in_r && (owner_q == 1'(gi));
        assign rvalid_vec[gi] = sel & axi.rvalid;
        assign rlast_vec[gi]  = sel & axi.rlast;
        assign rdata_arr[gi]  = sel ? axi.rdata : '0;
    end

    assign p0_addr_ok = addr_ok_vec[PORT_ICACHE];
    assign p0_rvalid  = rvalid_vec[PORT_ICACHE];
    assign p0_rlast   = rlast_vec[PORT_ICACHE];
    assign p0_rdata   = rdata_arr[PORT_ICACHE];

    assign p1_addr_ok = addr_ok_vec[PORT_DCACHE];
    assign p1_rvalid  = rvalid_vec[PORT_DCACHE];
    assign p1_rlast   = rlast_vec[PORT_DCACHE];
    assign p1_rdata   = rdata_arr[PORT_DCACHE];

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays the AXI slave itself.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;

    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr;
    logic [7:0]  p0_len, p1_len;
    logic [2:0]  p0_size, p1_size;
    logic        p0_addr_ok, p1_addr_ok;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_rvalid, p1_rvalid;
    logic        p0_rlast, p1_rlast;

    int checks   = 0;
    int failures = 0;

    axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

    axi_rd_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .ID_W       (4),
        .RESET_PRIO (1)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .p0_req     (p0_req),
        .p0_addr    (p0_addr),
        .p0_len     (p0_len),
        .p0_size    (p0_size),
        .p0_addr_ok (p0_addr_ok),
        .p0_rdata   (p0_rdata),
        .p0_rvalid  (p0_rvalid),
        .p0_rlast   (p0_rlast),
        .p1_req     (p1_req),
        .p1_addr    (p1_addr),
        .p1_len     (p1_len),
        .p1_size    (p1_size),
        .p1_addr_ok (p1_addr_ok),
        .p1_rdata   (p1_rdata),
        .p1_rvalid  (p1_rvalid),
        .p1_rlast   (p1_rlast),
        .axi        (axi)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Called the cycle after addr_ok: checks AR, optionally stalls arready,
    // then returns len+1 beats (data = addr + beat index) to the owner.
    task automatic serve(input int own, input logic [31:0] addr, input logic [7:0] len,
                         input int ar_wait);
        chk("ar_valid", axi.arvalid, 1);
        chk("ar_addr", axi.araddr, addr);
        chk("ar_len", axi.arlen, len);
        chk("ar_id", axi.arid, own);
        chk("ar_burst", axi.arburst, 2'b01);
        for (int w = 0; w < ar_wait; w++) begin
            axi.arready = 1'b0;
            tick();
            chk("ar_hold_valid", axi.arvalid, 1);
            chk("ar_hold_addr", axi.araddr, addr);
            chk("ar_hold_len", axi.arlen, len);
            chk("ar_hold_id", axi.arid, own);
            chk("ar_no_addr_ok", {p1_addr_ok, p0_addr_ok}, 2'b00);
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("ar_done_valid", axi.arvalid, 0);
        chk("r_rready", axi.rready, 1);
        for (int b = 0; b <= int'(len); b++) begin
            axi.rvalid = 1'b1;
            axi.rdata  = addr + 32'(b);
            axi.rlast  = (b == int'(len));
            #1;
            chk("beat_own_rvalid", own ? p1_rvalid : p0_rvalid, 1);
            chk("beat_own_rdata", own ? p1_rdata : p0_rdata, addr + 32'(b));
            chk("beat_own_rlast", own ? p1_rlast : p0_rlast, (b == int'(len)));
            chk("beat_other_rvalid", own ? p0_rvalid : p1_rvalid, 0);
            chk("beat_other_rlast", own ? p0_rlast : p1_rlast, 0);
            chk("beat_no_addr_ok", {p1_addr_ok, p0_addr_ok}, 2'b00);
            tick();
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        #1;
        chk("post_burst_rready", axi.rready, 0);
    endtask

    task automatic reset_dut();
        aresetn = 1'b0;
        #1;
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_araddr", axi.araddr, 0);
        chk("rst_arlen", axi.arlen, 0);
        chk("rst_arid", axi.arid, 0);
        chk("rst_p0_rvalid", p0_rvalid, 0);
        chk("rst_p1_rvalid", p1_rvalid, 0);
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        p0_req = 0; p0_addr = 0; p0_len = 0; p0_size = 0;
        p1_req = 0; p1_addr = 0; p1_len = 0; p1_size = 0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0;
        axi.rlast = 0; axi.rvalid = 0;
        aresetn = 1'b1;
        #2;
        reset_dut();

        // p0 only: 8-beat burst from the boot vector
        tick();
        p0_req = 1; p0_addr = 32'h1fc0_0000; p0_len = 8'd7; p0_size = 3'd2;
        #1;
        chk("t1_p0_addr_ok", p0_addr_ok, 1);
        chk("t1_p1_addr_ok", p1_addr_ok, 0);
        tick();
        p0_req = 0;
        chk("t1_arsize", axi.arsize, 3'd2);
        serve(0, 32'h1fc0_0000, 8'd7, 0);

        // Fresh reset, both request together: p1 first (arready stalled 5 cycles), p0, p1
        reset_dut();
        tick();
        p0_req = 1; p0_addr = 32'h0000_1000; p0_len = 8'd1;
        p1_req = 1; p1_addr = 32'h0000_2000; p1_len = 8'd1;
        #1;
        chk("t2_first_grant", {p1_addr_ok, p0_addr_ok}, 2'b10);
        tick();
        p1_req = 0;
        serve(1, 32'h0000_2000, 8'd1, 5);
        p1_req = 1; p1_addr = 32'h0000_3000; p1_len = 8'd2;
        #1;
        chk("t2_second_grant", {p1_addr_ok, p0_addr_ok}, 2'b01);
        tick();
        p0_req = 0;
        serve(0, 32'h0000_1000, 8'd1, 0);
        chk("t2_third_grant", {p1_addr_ok, p0_addr_ok}, 2'b10);
        tick();
        p1_req = 0;
        serve(1, 32'h0000_3000, 8'd2, 0);

        // p1 arrives during a p0 burst: granted one cycle after the rlast beat
        tick();
        p0_req = 1; p0_addr = 32'h0000_4000; p0_len = 8'd3;
        #1;
        chk("t3_p0_addr_ok", p0_addr_ok, 1);
        tick();
        p0_req = 0;
        p1_req = 1; p1_addr = 32'h0000_5000; p1_len = 8'd0;
        serve(0, 32'h0000_4000, 8'd3, 1);
        chk("t3_p1_addr_ok_after_rlast", p1_addr_ok, 1);
        tick();
        p1_req = 0;
        serve(1, 32'h0000_5000, 8'd0, 0);

        // Reset at beat 3 of an 8-beat p1 burst; then prio is back at port 1
        reset_dut();
        tick();
        p0_req = 1; p0_addr = 32'h0000_6000; p0_len = 8'd7;
        p1_req = 1; p1_addr = 32'h0000_7000; p1_len = 8'd7;
        #1;
        chk("t4_grant", {p1_addr_ok, p0_addr_ok}, 2'b10);
        tick();
        p0_req = 0; p1_req = 0;
        axi.arready = 1;
        tick();
        axi.arready = 0;
        for (int b = 0; b < 3; b++) begin
            axi.rvalid = 1; axi.rdata = 32'h0000_7000 + 32'(b); axi.rlast = 0;
            #1;
            chk("t4_p1_rdata", p1_rdata, 32'h0000_7000 + 32'(b));
            tick();
        end
        axi.rvalid = 1; axi.rdata = 32'h0000_7003;
        #1;
        chk("t4_beat3_rvalid", p1_rvalid, 1);
        aresetn = 0;
        #1;
        chk("t4_async_arvalid", axi.arvalid, 0);
        chk("t4_async_rready", axi.rready, 0);
        chk("t4_async_p1_rvalid", p1_rvalid, 0);
        chk("t4_async_arid", axi.arid, 0);
        axi.rvalid = 0;
        tick();
        aresetn = 1;
        tick();
        p0_req = 1; p0_addr = 32'h0000_8000; p0_len = 8'd0;
        p1_req = 1; p1_addr = 32'h0000_9000; p1_len = 8'd0;
        #1;
        chk("t4_post_rst_grant", {p1_addr_ok, p0_addr_ok}, 2'b10);
        tick();
        p1_req = 0; p0_req = 0;
        serve(1, 32'h0000_9000, 8'd0, 0);

        // rvalid in IDLE is ignored; len 0 burst with rvalid gaps
        axi.rvalid = 1; axi.rlast = 1; axi.rdata = 32'hdead_beef;
        #1;
        chk("t5_idle_rready", axi.rready, 0);
        chk("t5_idle_p0_rvalid", p0_rvalid, 0);
        chk("t5_idle_p1_rvalid", p1_rvalid, 0);
        tick();
        axi.rvalid = 0; axi.rlast = 0;
        p0_req = 1; p0_addr = 32'h0000_a000; p0_len = 8'd0;
        #1;
        chk("t5_p0_addr_ok", p0_addr_ok, 1);
        tick();
        p0_req = 0;
        chk("t5_arlen", axi.arlen, 0);
        axi.arready = 1;
        tick();
        axi.arready = 0;
        for (int g = 0; g < 2; g++) begin
            #1;
            chk("t5_gap_rready", axi.rready, 1);
            chk("t5_gap_p0_rvalid", p0_rvalid, 0);
            tick();
        end
        axi.rvalid = 1; axi.rlast = 1; axi.rdata = 32'h0000_a000;
        #1;
        chk("t5_single_rvalid", p0_rvalid, 1);
        chk("t5_single_rlast", p0_rlast, 1);
        tick();
        axi.rvalid = 0; axi.rlast = 0;
        #1;
        chk("t5_back_idle_rready", axi.rready, 0);
        chk("t5_back_idle_arvalid", axi.arvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
